mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Memory-stage load/store unit between the EX/MEM latch and the data cache (decache).
//  Successor to the single-request memory handler: adds valid/ready pipeline handshake,
//  a STB_DEPTH-entry posted store buffer, byte-lane extraction plus sign/zero extension of
//  loads, misalignment detection and snoop-stall gating of cache issue.
// PARAMETERS
//  XLEN       64  data path width; load lane logic assumes 64 (8 byte lanes)
//  ADDR_W     64  address width
//  STB_DEPTH  4   store buffer entries, power of two, >=2
// PORTS
//  clk              in   1       clock
//  reset            in   1       asynchronous, active-high reset
//  ex_valid         in   1       EX/MEM holds a valid instruction
//  ex_ready         out  1       LSU accepts the instruction this cycle
//  alu_data         in   ADDR_W  effective address
//  reg_b_contents   in   XLEN    store data, right-aligned
//  read_mem         in   1       instruction is a load
//  write_mem        in   1       instruction is a store (read_mem and write_mem never both 1)
//  data_size        in   3       [1:0] log2 bytes (0..3); [2] 1 = zero-extend load
//  drain_req        in   1       fence: accept nothing until store buffer empty
//  snoop_stall      in   1       cache servicing snoop; issue no new cache op
//  wb_valid         out  1       result valid for MEM/WB
//  wb_ready         in   1       MEM/WB latches result
//  loaded_data_out  out  XLEN    extended load data (0 for stores / non-memory ops)
//  misaligned       out  1       valid with wb_valid; access not naturally aligned
//  stb_empty        out  1       store buffer empty and no write in flight
//  dc_read_enable   out  1       level request to cache, held until dc_send_enable
//  dc_write_enable  out  1       level request to cache, held until dc_send_enable
//  dc_address       out  ADDR_W  cache address
//  dc_data_size     out  3       size to cache
//  dc_wdata         out  XLEN    store data to cache
//  dc_send_enable   in   1       one-cycle completion pulse from cache
//  dc_rdata         in   XLEN    doubleword containing address, valid with dc_send_enable
// BEHAVIOUR
//  Reset: FSM=IDLE, stb empty, all outputs 0 except ex_ready=0, stb_empty=1.
//  FSM: IDLE, LD_ISSUE, LD_WAIT, ST_DRAIN, HOLD.
//  Acceptance (IDLE only, ex_ready=1): none if drain_req && !stb_empty.
//   non-memory op: -> HOLD next cycle, loaded_data_out=0, misaligned=0.
//   misaligned (addr[size-1:0]!=0): no cache op, no stb write; -> HOLD, misaligned=1.
//   store: enqueue {addr,data,size} if stb not full (ex_ready=0 when full); -> HOLD.
//   load: if any valid stb entry's 8-byte block (addr[ADDR_W-1:3]) matches -> stay IDLE,
//    ex_ready=0, drain until no match; else -> LD_ISSUE.
//  LD_ISSUE: when !snoop_stall and no write in flight assert dc_read_enable -> LD_WAIT.
//  LD_WAIT: hold dc_read_enable/address/size stable; on dc_send_enable drop request same
//   cycle, capture lane = dc_rdata >> (8*addr[2:0]), mask to size, sign/zero extend -> HOLD.
//  HOLD: wb_valid=1, outputs stable until wb_ready; on wb_ready -> IDLE, wb_valid=0 next cycle.
//   Min latency: store/non-mem 1 cycle accept->wb_valid; load hit 1+cache latency+1.
//  Drain (ST_DRAIN, entered from IDLE when stb non-empty, no load pending in LD_ISSUE/WAIT,
//   !snoop_stall): head entry on dc_write_enable until dc_send_enable; then pop, -> IDLE.
//   A started write always completes; snoop_stall only blocks starting one.
//   Loads waiting on a conflict take drain priority; otherwise drain runs opportunistically.
//  Simultaneous: enqueue and pop in same cycle allowed when full (count unchanged).
//   Pointers wrap modulo STB_DEPTH; count width clog2(STB_DEPTH)+1.
//  dc_read_enable and dc_write_enable never both 1.
//  Reset mid-operation: outstanding cache request dropped, buffered stores discarded.
// STRUCTURE
//  Package lsu_pkg: lsu_state_e enum, stb_entry_t struct {addr,data,size},
//   SIZE_B/H/W/D constants, function load_extend(rdata, addr[2:0], size).
//  Sub-module lsu_store_buffer: circular FIFO, push/pop/full/empty, head output,
//   combinational block-address match vector over valid entries.
// TESTING
//  ld 0x1004 size=2 signed, dc_rdata=0x8000_0001_0000_0000 -> wb loaded_data_out=0xFFFF_FFFF_8000_0001.
//  lbu 0x1007, dc_rdata=0xAB00_..._00 -> 0x0000_0000_0000_00AB; lb same -> 0xFFFF_FFFF_FFFF_FFAB.
//  5 back-to-back stores, STB_DEPTH=4, cache latency 3 -> 5th ex_ready=0 until first drain pop; order kept.
//  sd 0x2000 then ld 0x2004 -> load not issued until write 0x2000 completes; no read before write.
//  lw 0x3002 -> misaligned=1, no dc_*_enable asserted, store buffer unchanged.
//  snoop_stall=1 with pending load -> no dc_read_enable until low; reset during LD_WAIT -> all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Lane extraction and extension of loaded doublewords live here.
package lsu_pkg;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 64;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    LD_ISSUE,
    LD_WAIT,
    ST_DRAIN,
    HOLD
  } lsu_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
    logic [2:0]        size;
  } stb_entry_t;

  function automatic logic [XLEN-1:0] load_extend(
    input logic [XLEN-1:0] rdata,
    input logic [2:0]      off,
    input logic [2:0]      size
  );
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] r;
    lane = rdata >> {off, 3'b000};
    r    = lane;
    unique case (size[1:0])
      SIZE_B[1:0]: r = size[2] ? {56'b0, lane[7:0]}
                               : {{56{lane[7]}}, lane[7:0]};
      SIZE_H[1:0]: r = size[2] ? {48'b0, lane[15:0]}
                               : {{48{lane[15]}}, lane[15:0]};
      SIZE_W[1:0]: r = size[2] ? {32'b0, lane[31:0]}
                               : {{32{lane[31]}}, lane[31:0]};
      SIZE_D[1:0]: r = lane;
      default:     r = lane;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_store_buffer.sv
// Posted store buffer: circular FIFO with a per-entry block match
// so younger loads can wait on overlapping buffered stores.
module lsu_store_buffer
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  stb_entry_t        push_entry,
  input  logic [ADDR_W-4:0] blk,
  output logic              full,
  output logic              empty,
  output stb_entry_t        head,
  output logic [DEPTH-1:0]  match
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  stb_entry_t      mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rel [DEPTH];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // An entry is live when its distance from the head is below count
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel[i]   = PW'(i) - rd_ptr;
      match[i] = ({1'b0, rel[i]} < count)
              && (mem[i].addr[ADDR_W-1:3] == blk);
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: accepts EX/MEM ops, buffers stores,
// issues loads to the data cache and presents results to MEM/WB.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int STB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] alu_data,
  input  logic [XLEN-1:0]   reg_b_contents,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic [2:0]        data_size,
  input  logic              drain_req,
  input  logic              snoop_stall,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   loaded_data_out,
  output logic              misaligned,
  output logic              stb_empty,
  output logic              dc_read_enable,
  output logic              dc_write_enable,
  output logic [ADDR_W-1:0] dc_address,
  output logic [2:0]        dc_data_size,
  output logic [XLEN-1:0]   dc_wdata,
  input  logic              dc_send_enable,
  input  logic [XLEN-1:0]   dc_rdata
);

  lsu_state_e             state;
  lsu_state_e             nstate;
  logic [ADDR_W-1:0]      ld_addr;
  logic [2:0]             ld_size;
  logic [XLEN-1:0]        res_q;
  logic                   mis_q;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  stb_entry_t             head;
  stb_entry_t             push_entry;
  logic [STB_DEPTH-1:0]   match;
  logic [2:0]             amask;
  logic                   misal;

  assign amask = 3'((4'd1 << data_size[1:0]) - 4'd1);
  assign misal = (read_mem | write_mem)
              && |(alu_data[2:0] & amask);

  assign push_entry = '{addr: alu_data,
                        data: reg_b_contents,
                        size: data_size};

  lsu_store_buffer #(.DEPTH(STB_DEPTH)) u_stb (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .blk        (alu_data[ADDR_W-1:3]),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .match      (match)
  );

  always_comb begin
    nstate          = state;
    ex_ready        = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    dc_read_enable  = 1'b0;
    dc_write_enable = 1'b0;
    dc_address      = '0;
    dc_data_size    = '0;
    dc_wdata        = '0;
    unique case (state)
      IDLE: begin
        if (ex_valid && !(drain_req && !empty)
            && !(write_mem && !misal && full)
            && !(read_mem && !misal && |match)) begin
          ex_ready = 1'b1;
          push     = write_mem && !misal;
          nstate   = (read_mem && !misal) ? LD_ISSUE : HOLD;
        end else if (!empty && !snoop_stall) begin
          nstate = ST_DRAIN;
        end
      end
      LD_ISSUE: begin
        dc_address   = ld_addr;
        dc_data_size = ld_size;
        if (!snoop_stall) begin
          dc_read_enable = 1'b1;
          nstate         = LD_WAIT;
        end
      end
      LD_WAIT: begin
        dc_read_enable = !dc_send_enable;
        dc_address     = ld_addr;
        dc_data_size   = ld_size;
        if (dc_send_enable) nstate = HOLD;
      end
      ST_DRAIN: begin
        dc_write_enable = !dc_send_enable;
        dc_address      = head.addr;
        dc_data_size    = head.size;
        dc_wdata        = head.data;
        if (dc_send_enable) begin
          pop    = 1'b1;
          nstate = IDLE;
        end
      end
      HOLD: begin
        if (wb_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ld_addr <= '0;
      ld_size <= '0;
      res_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state <= nstate;
      if (ex_ready) begin
        ld_addr <= alu_data;
        ld_size <= data_size;
        res_q   <= '0;
        mis_q   <= misal;
      end
      if (state == LD_WAIT && dc_send_enable)
        res_q <= load_extend(dc_rdata, ld_addr[2:0], ld_size);
    end
  end

  assign wb_valid        = (state == HOLD);
  assign loaded_data_out = wb_valid ? res_q : '0;
  assign misaligned      = wb_valid & mis_q;
  assign stb_empty       = empty && (state != ST_DRAIN);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: byte-level memory model plus a latency-3
// cache responder; directed loads/stores with literal expectations.
module tb_mem_stage_lsu;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [63:0] alu_data = '0;
  logic [63:0] reg_b_contents = '0;
  logic        read_mem = 1'b0;
  logic        write_mem = 1'b0;
  logic [2:0]  data_size = '0;
  logic        drain_req = 1'b0;
  logic        snoop_stall = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [63:0] loaded_data_out;
  logic        misaligned;
  logic        stb_empty;
  logic        dc_read_enable;
  logic        dc_write_enable;
  logic [63:0] dc_address;
  logic [2:0]  dc_data_size;
  logic [63:0] dc_wdata;
  logic        dc_send_enable = 1'b0;
  logic [63:0] dc_rdata = '0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.STB_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .alu_data        (alu_data),
    .reg_b_contents  (reg_b_contents),
    .read_mem        (read_mem),
    .write_mem       (write_mem),
    .data_size       (data_size),
    .drain_req       (drain_req),
    .snoop_stall     (snoop_stall),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .loaded_data_out (loaded_data_out),
    .misaligned      (misaligned),
    .stb_empty       (stb_empty),
    .dc_read_enable  (dc_read_enable),
    .dc_write_enable (dc_write_enable),
    .dc_address      (dc_address),
    .dc_data_size    (dc_data_size),
    .dc_wdata        (dc_wdata),
    .dc_send_enable  (dc_send_enable),
    .dc_rdata        (dc_rdata)
  );

  typedef struct { logic [63:0] d; logic m; } wb_t;
  typedef struct { logic [63:0] a; logic [63:0] d; logic [2:0] s; } st_t;

  logic [7:0] cmem [logic [63:0]];
  logic [7:0] refb [logic [63:0]];
  wb_t expq[$];
  st_t stq[$];
  int  n_pass = 0;
  int  n_tot = 0;
  int  wr_done = 0;
  int  req_cyc = 0;
  int  lat = 0;
  bit  resp_wr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  task automatic bad(input string nm);
    n_tot++;
    $display("FAIL %s: got 0, required 1", nm);
  endtask

  function automatic logic [7:0] cb(input logic [63:0] a);
    return cmem.exists(a) ? cmem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rb(input logic [63:0] a);
    return refb.exists(a) ? refb[a] : 8'h00;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a,
                                             input logic [2:0] sz);
    int nb = 1 << sz[1:0];
    logic [63:0] v = '0;
    for (int b = 0; b < nb; b++) v[8*b+:8] = rb(a + 64'(b));
    if (!sz[2] && v[8*nb-1])
      for (int k = 8*nb; k < 64; k++) v[k] = 1'b1;
    return v;
  endfunction

  task automatic poke(input logic [63:0] a, input logic [63:0] d);
    for (int b = 0; b < 8; b++) begin
      cmem[a + 64'(b)] = d[8*b+:8];
      refb[a + 64'(b)] = d[8*b+:8];
    end
  endtask

  // Cache: answers any request LAT cycles after it is first seen
  always @(posedge clk) begin
    #2;
    dc_send_enable = 1'b0;
    if (reset || !(dc_read_enable || dc_write_enable)) lat = 0;
    else if (lat == LAT - 1) begin
      lat = 0;
      dc_send_enable = 1'b1;
      resp_wr = dc_write_enable;
      if (dc_write_enable)
        for (int b = 0; b < (1 << dc_data_size[1:0]); b++)
          cmem[dc_address + 64'(b)] = dc_wdata[8*b+:8];
      else
        for (int b = 0; b < 8; b++)
          dc_rdata[8*b+:8] = cb({dc_address[63:3], 3'b000} + 64'(b));
    end else lat++;
  end

  always @(negedge clk) begin
    int nb;
    bit mis;
    wb_t e;
    st_t s;
    logic [63:0] msk;
    if (reset) begin
      expq.delete();
      stq.delete();
      refb = cmem;
    end else begin
      chk("rd_wr_exclusive",
          {63'b0, dc_read_enable & dc_write_enable}, 64'd0);
      if (dc_read_enable || dc_write_enable) req_cyc++;
      if (ex_valid && ex_ready) begin
        nb  = 1 << data_size[1:0];
        msk = (nb == 8) ? '1 : ((64'd1 << (8*nb)) - 64'd1);
        mis = (read_mem || write_mem) && (alu_data % 64'(nb) != 0);
        if ((!read_mem && !write_mem) || mis)
          expq.push_back('{d: 64'd0, m: mis});
        else if (write_mem) begin
          for (int b = 0; b < nb; b++)
            refb[alu_data + 64'(b)] = reg_b_contents[8*b+:8];
          stq.push_back('{a: alu_data, d: reg_b_contents & msk,
                          s: data_size});
          expq.push_back('{d: 64'd0, m: 1'b0});
        end else
          expq.push_back('{d: model_load(alu_data, data_size), m: 1'b0});
      end
      if (dc_send_enable && resp_wr) begin
        wr_done++;
        if (stq.size() == 0) bad("unexpected_write");
        else begin
          s   = stq.pop_front();
          nb  = 1 << s.s[1:0];
          msk = (nb == 8) ? '1 : ((64'd1 << (8*nb)) - 64'd1);
          chk("write_addr", dc_address, s.a);
          chk("write_data", dc_wdata & msk, s.d);
          chk("write_size", {61'b0, dc_data_size}, {61'b0, s.s});
        end
      end
      if (wb_valid && wb_ready) begin
        if (expq.size() == 0) bad("unexpected_wb");
        else begin
          e = expq.pop_front();
          chk("wb_data", loaded_data_out, e.d);
          chk("wb_misaligned", {63'b0, misaligned}, {63'b0, e.m});
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic wr,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic [2:0] sz, output int stall);
    stall = 0;
    ex_valid = 1'b1;
    read_mem = rd;
    write_mem = wr;
    alu_data = a;
    reg_b_contents = d;
    data_size = sz;
    @(negedge clk);
    while (!ex_ready && stall < 300) begin
      stall++;
      @(negedge clk);
    end
    if (!ex_ready) bad("accept_timeout");
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    read_mem = 1'b0;
    write_mem = 1'b0;
  endtask

  task automatic get_wb(output logic [63:0] d, output logic m);
    int n = 0;
    @(negedge clk);
    while (!wb_valid && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!wb_valid) bad("wb_timeout");
    d = loaded_data_out;
    m = misaligned;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    int n = 0;
    @(negedge clk);
    while (!stb_empty && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!stb_empty) bad("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [2:0] sz,
                      output logic [63:0] d, output logic m);
    int st;
    issue(1'b1, 1'b0, a, 64'd0, sz, st);
    get_wb(d, m);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic        m;
    int st;
    int w0;
    int r0;
    int stall5;
    int wd5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_ready", {63'b0, ex_ready}, 64'd0);
    chk("rst_stb_empty", {63'b0, stb_empty}, 64'd1);
    chk("rst_wb_valid", {63'b0, wb_valid}, 64'd0);
    chk("rst_dc_read", {63'b0, dc_read_enable}, 64'd0);
    chk("rst_dc_write", {63'b0, dc_write_enable}, 64'd0);
    chk("rst_loaded", loaded_data_out, 64'd0);
    chk("rst_misaligned", {63'b0, misaligned}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    poke(64'h1000, 64'h8000_0001_0000_0000);
    load(64'h1004, 3'b010, d, m);
    chk("lw_signed", d, 64'hFFFF_FFFF_8000_0001);

    poke(64'h1000, 64'hAB00_0000_0000_0000);
    load(64'h1007, 3'b100, d, m);
    chk("lbu", d, 64'h0000_0000_0000_00AB);
    load(64'h1007, 3'b000, d, m);
    chk("lb", d, 64'hFFFF_FFFF_FFFF_FFAB);

    issue(1'b0, 1'b0, 64'h1234, 64'h55, 3'b011, st);
    get_wb(d, m);
    chk("nop_data", d, 64'd0);
    chk("nop_mis", {63'b0, m}, 64'd0);

    issue(1'b0, 1'b1, 64'h2000, 64'h1234_5678_9ABC_DEF0, 3'b011, st);
    get_wb(d, m);
    w0 = wr_done;
    issue(1'b1, 1'b0, 64'h2004, 64'd0, 3'b110, st);
    chk("raw_write_first", 64'(wr_done - w0), 64'd1);
    chk("raw_wait", {63'b0, st >= 3}, 64'd1);
    get_wb(d, m);
    chk("lwu_after_sd", d, 64'h0000_0000_1234_5678);

    issue(1'b0, 1'b1, 64'h6002, 64'hFFFF_BEEF, 3'b001, st);
    get_wb(d, m);
    load(64'h6002, 3'b101, d, m);
    chk("lhu", d, 64'h0000_0000_0000_BEEF);
    load(64'h6002, 3'b001, d, m);
    chk("lh", d, 64'hFFFF_FFFF_FFFF_BEEF);
    load(64'h6003, 3'b000, d, m);
    chk("lb_hi", d, 64'hFFFF_FFFF_FFFF_FFBE);

    wait_empty();
    r0 = req_cyc;
    load(64'h3002, 3'b010, d, m);
    chk("mis_flag", {63'b0, m}, 64'd1);
    chk("mis_data", d, 64'd0);
    chk("mis_no_cache_op", 64'(req_cyc - r0), 64'd0);
    chk("mis_stb_empty", {63'b0, stb_empty}, 64'd1);

    w0 = wr_done;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 1'b1, 64'h4000 + 64'(8*i),
            64'h1111_1111_1111_1111 * 64'(i + 1), 3'b011, st);
      if (i == 4) begin
        stall5 = st;
        wd5 = wr_done - w0;
      end
    end
    chk("fifth_after_one_pop", 64'(wd5), 64'd1);
    chk("fifth_stalled", {63'b0, stall5 > 3}, 64'd1);
    load(64'h4000, 3'b011, d, m);
    chk("st0_data", d, 64'h1111_1111_1111_1111);
    load(64'h4020, 3'b011, d, m);
    chk("st4_data", d, 64'h5555_5555_5555_5555);

    wait_empty();
    w0 = wr_done;
    issue(1'b0, 1'b1, 64'h7000, 64'hCAFE, 3'b011, st);
    drain_req = 1'b1;
    issue(1'b0, 1'b0, 64'h0, 64'h0, 3'b000, st);
    drain_req = 1'b0;
    chk("fence_drained", 64'(wr_done - w0), 64'd1);
    get_wb(d, m);

    wait_empty();
    snoop_stall = 1'b1;
    r0 = req_cyc;
    issue(1'b1, 1'b0, 64'h2000, 64'd0, 3'b011, st);
    repeat (5) @(posedge clk);
    #1;
    chk("snoop_no_read", 64'(req_cyc - r0), 64'd0);
    snoop_stall = 1'b0;
    get_wb(d, m);
    chk("ld_after_snoop", d, 64'h1234_5678_9ABC_DEF0);

    issue(1'b0, 1'b1, 64'h5000, 64'hDEAD, 3'b011, st);
    issue(1'b1, 1'b0, 64'h1000, 64'd0, 3'b011, st);
    st = 0;
    @(negedge clk);
    while (!dc_read_enable && st < 50) begin
      st++;
      @(negedge clk);
    end
    if (!dc_read_enable) bad("read_timeout");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_read", {63'b0, dc_read_enable}, 64'd0);
    chk("mid_rst_write", {63'b0, dc_write_enable}, 64'd0);
    chk("mid_rst_addr", dc_address, 64'd0);
    chk("mid_rst_wb", {63'b0, wb_valid}, 64'd0);
    chk("mid_rst_data", loaded_data_out, 64'd0);
    chk("mid_rst_stb_empty", {63'b0, stb_empty}, 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    load(64'h5000, 3'b011, d, m);
    chk("store_discarded", d, 64'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
